// File: rtl/stream_mux_arb_if.sv
// Handshake bundle between N stream producers, the arbitrating mux and one consumer.
// The producer/consumer side uses the master modport; the mux uses slave.
interface stream_mux_arb_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
);
   logic                         mode;
   logic [SEL_W-1:0]             sel;
   logic [CHANNELS-1:0]          in_valid;
   logic [CHANNELS*WIDTH-1:0]    in_data;
   logic [CHANNELS-1:0]          in_ready;
   logic                         out_valid;
   logic [WIDTH-1:0]             out_data;
   logic [SEL_W-1:0]             out_ch;
   logic                         out_ready;

   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );
endinterface

// File: rtl/stream_mux_arb.sv
// N-channel registered stream mux: one beat per cycle is granted either by an explicit
// select or round-robin, and held in a single output register until the consumer takes it.
module stream_mux_arb #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   stream_mux_arb_if.slave        bus
);
   localparam int SLOTS = 2 ** SEL_W;

   logic [SLOTS-1:0]  valid_pad;
   logic [WIDTH-1:0]  ch_data [SLOTS];
   logic [SEL_W-1:0]  grant;
   logic              grant_vld;
   logic              can_load;
   logic              xfer;
   int                cand;

   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_data_q,  out_data_d;
   logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
   logic [SEL_W-1:0]  ptr_q,       ptr_d;

   // Unused select codes read as never-valid with zero data, so an out-of-range sel never grants.
   always_comb begin
      valid_pad                 = '0;
      valid_pad[CHANNELS-1:0]   = bus.in_valid;
   end

   for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < CHANNELS) begin : g_used
         assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
      end else begin : g_pad
         assign ch_data[gi] = '0;
      end
   end

   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      cand      = 0;
      if (!bus.mode) begin
         if (valid_pad[bus.sel]) begin
            grant     = bus.sel;
            grant_vld = 1'b1;
         end
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= CHANNELS) cand = cand - CHANNELS;
            if (!grant_vld && valid_pad[SEL_W'(cand)]) begin
               grant     = SEL_W'(cand);
               grant_vld = 1'b1;
            end
         end
      end
   end

   // Loading while the held beat drains in the same cycle keeps full throughput.
   assign can_load = !out_valid_q || bus.out_ready;
   assign xfer     = grant_vld && can_load;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
      assign bus.in_ready[gi] = xfer && (grant == SEL_W'(gi));
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = ch_data[grant];
         out_ch_d    = grant;
         if (bus.mode) begin
            ptr_d = (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: a reference model predicts grants and in_ready,
// accepted beats are queued and matched against the output when the consumer takes them.
module tb_stream_mux_arb;
   localparam int WIDTH    = 8;
   localparam int CHANNELS = 4;
   localparam int SEL_W    = 2;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   logic [SEL_W+WIDTH-1:0] sb_q [$];
   logic                   m_valid;
   logic [SEL_W-1:0]       m_ptr;

   stream_mux_arb_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus ();

   stream_mux_arb #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant(input logic md, input logic [SEL_W-1:0] s,
                                      input logic [CHANNELS-1:0] v, input logic [SEL_W-1:0] p);
      int g;
      g = -1;
      if (!md) begin
         if (int'(s) < CHANNELS && v[s]) g = int'(s);
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (g < 0 && v[(int'(p) + k) % CHANNELS]) g = (int'(p) + k) % CHANNELS;
         end
      end
      return g;
   endfunction

   // One clock: predict and check at the falling edge, then advance past the rising edge.
   task automatic cycle(input string tag);
      int                      g;
      logic                    can_load;
      logic                    xfer;
      logic [CHANNELS-1:0]     exp_ready;
      logic [SEL_W+WIDTH-1:0]  exp_beat;
      @(negedge clk);
      can_load  = !m_valid || bus.out_ready;
      g         = model_grant(bus.mode, bus.sel, bus.in_valid, m_ptr);
      xfer      = (g >= 0) && can_load;
      exp_ready = xfer ? CHANNELS'(1 << g) : '0;
      check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_ready));
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
      check({tag, ".ptr"}, 32'(dut.ptr_q), 32'(m_ptr));
      if (bus.out_valid && bus.out_ready) begin
         check({tag, ".sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            exp_beat = sb_q.pop_front();
            check({tag, ".out_ch"}, 32'(bus.out_ch), 32'(exp_beat[SEL_W+WIDTH-1:WIDTH]));
            check({tag, ".out_data"}, 32'(bus.out_data), 32'(exp_beat[WIDTH-1:0]));
         end
      end
      if (xfer) begin
         sb_q.push_back({SEL_W'(g), bus.in_data[g*WIDTH +: WIDTH]});
         if (bus.mode) m_ptr = (g == CHANNELS - 1) ? '0 : SEL_W'(g + 1);
         m_valid = 1'b1;
      end else if (bus.out_ready) begin
         m_valid = 1'b0;
      end
      $display("[%0t] %s mode=%0b sel=%0d in_valid=%b out_ready=%0b grant=%0d out_valid=%0b out_ch=%0d out_data=%02h",
               $time, tag, bus.mode, bus.sel, bus.in_valid, bus.out_ready, g,
               bus.out_valid, bus.out_ch, bus.out_data);
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_valid = 1'b0;
      m_ptr   = '0;
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.mode      = 1'b0;
      bus.sel       = '0;
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset.out_valid", 32'(bus.out_valid), 32'd0);
      check("reset.out_data", 32'(bus.out_data), 32'd0);
      check("reset.out_ch", 32'(bus.out_ch), 32'd0);
      check("reset.in_ready", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b1;

      // Fixed select of channel 2 with every channel offering.
      bus.mode      = 1'b0;
      bus.sel       = 2'd2;
      bus.in_valid  = 4'b1111;
      bus.in_data   = 32'h4433_2211;
      bus.out_ready = 1'b1;
      repeat (4) cycle("fixed");

      // Round-robin with all channels valid, fresh data each beat.
      bus.mode = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.in_data = $urandom;
         cycle("rr_all");
      end

      bus.in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         bus.in_data = $urandom;
         cycle("rr_sparse");
      end

      // Back-pressure: held beat must survive three stalled cycles.
      bus.in_valid  = 4'b1111;
      bus.in_data   = 32'hA5B6_C7D8;
      bus.out_ready = 1'b0;
      repeat (3) cycle("stall");
      bus.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.in_data = $urandom;
         cycle("unstall");
      end

      // Fixed-mode detour leaves the round-robin pointer untouched.
      check("switch.ptr_before", 32'(dut.ptr_q), 32'd2);
      bus.mode = 1'b0;
      bus.sel  = 2'd0;
      for (int i = 0; i < 2; i++) begin
         bus.in_data = $urandom;
         cycle("switch_fixed");
      end
      bus.mode = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.in_data = $urandom;
         cycle("switch_rr");
      end

      bus.in_valid = '0;
      repeat (2) cycle("drain");

      // Asynchronous reset while a beat is stalled in the output register.
      bus.in_valid  = 4'b1111;
      bus.in_data   = 32'h1234_5678;
      bus.out_ready = 1'b0;
      repeat (2) cycle("pre_reset");
      #2 rst_n = 1'b0;
      #1;
      check("async_reset.out_valid", 32'(bus.out_valid), 32'd0);
      check("async_reset.out_data", 32'(bus.out_data), 32'd0);
      check("async_reset.out_ch", 32'(bus.out_ch), 32'd0);
      check("async_reset.ptr", 32'(dut.ptr_q), 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 4'b0100;
      bus.in_data   = 32'h00EE_0000;
      cycle("post_reset");
      bus.in_valid = '0;
      repeat (2) cycle("post_reset_drain");
      check("final.sb_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
